// File: rtl/usb_rx_if.sv
// rtl/usb_rx_if.sv - USB full-speed receiver pin/FIFO-side signal bundle
// Purpose: groups the receiver's line inputs, FIFO occupancy and packet outputs.
// Signals:
//   dplus_in, dminus_in   USB line pair (idle J: dplus=1, dminus=0)
//   buffer_occupancy      RX FIFO byte count, 0..64
//   rx_packet             last received PID nibble
//   rx_packet_data        last completed byte after the PID
//   store_rx_packet_data  one-cycle FIFO push strobe
//   flush                 one-cycle strobe on DATA0/DATA1 PID acceptance
//   rx_error              sticky packet error flag
//   rx_trans_active       high from SYNC start to EOP completion
//   rx_data_ready         one-cycle strobe: DATA packet ended cleanly
// Modports: master drives the line and occupancy; slave is the receiver.
interface usb_rx_if;
  logic       dplus_in;
  logic       dminus_in;
  logic [6:0] buffer_occupancy;
  logic [3:0] rx_packet;
  logic [7:0] rx_packet_data;
  logic       store_rx_packet_data;
  logic       flush;
  logic       rx_error;
  logic       rx_trans_active;
  logic       rx_data_ready;

  modport master (
    output dplus_in, dminus_in, buffer_occupancy,
    input  rx_packet, rx_packet_data, store_rx_packet_data, flush,
           rx_error, rx_trans_active, rx_data_ready
  );

  modport slave (
    input  dplus_in, dminus_in, buffer_occupancy,
    output rx_packet, rx_packet_data, store_rx_packet_data, flush,
           rx_error, rx_trans_active, rx_data_ready
  );
endinterface

// File: rtl/usb_rx.sv
// rtl/usb_rx.sv - USB full-speed receive front end
// Purpose: recovers bits from D+/D- (NRZI decode, bit unstuffing, EOP detect),
//   validates SYNC and PID, reports the packet type and streams DATA-packet
//   bytes into the RX FIFO.
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset
//   bus    usb_rx_if.slave: line pair and FIFO occupancy in; PID nibble, byte,
//          store/flush/ready strobes, error and activity flags out
module usb_rx #(
  parameter int BIT_PERIOD = 5
) (
  input  logic     clk,
  input  logic     n_rst,
  usb_rx_if.slave  bus
);
  localparam int CW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CW-1:0] HALF = CW'(BIT_PERIOD / 2);
  localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);

  localparam logic [1:0] K_BAD = 2'd0, K_TOKEN = 2'd1, K_DATA = 2'd2, K_HS = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_HANDSHAKE, S_ERR_WAIT, S_EOP
  } state_t;

  state_t state, nxt;

  logic          dp_s1, dp_s2, dp_prev, dm_s1, dm_s2;
  logic [CW-1:0] cnt;
  logic          last_lvl;
  logic [2:0]    ones;
  logic [2:0]    bit_cnt;
  logic [7:0]    sr;
  logic [1:0]    tok_cnt;
  logic          data_pkt;

  logic [3:0]    rx_packet_q;
  logic [7:0]    rx_packet_data_q;
  logic          store_q, flush_q, rx_error_q, trans_active_q, ready_q;

  logic dp_edge, samp, se0, line_j, bit_d, stuff, bit_v, byte_done, sync_start, occ_full;
  logic [7:0] byte_w;
  logic [1:0] kind;

  logic pkt_load, data_load, store_d, flush_d, err_set, ready_d, eop_done;

  function automatic logic [1:0] pid_kind(input logic [7:0] p);
    logic [1:0] k;
    k = K_BAD;
    if (p[7:4] == ~p[3:0]) begin
      case (p[3:0])
        4'b0001, 4'b1001:          k = K_TOKEN;
        4'b0011, 4'b1011:          k = K_DATA;
        4'b0010, 4'b1010, 4'b1110: k = K_HS;
        default:                   k = K_BAD;
      endcase
    end
    return k;
  endfunction

  // Two-flop synchronizers; dp_prev gives one more stage for D+ edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_s1   <= 1'b1;
      dp_s2   <= 1'b1;
      dp_prev <= 1'b1;
      dm_s1   <= 1'b0;
      dm_s2   <= 1'b0;
    end else begin
      dp_s1   <= bus.dplus_in;
      dp_s2   <= dp_s1;
      dp_prev <= dp_s2;
      dm_s1   <= bus.dminus_in;
      dm_s2   <= dm_s1;
    end
  end

  assign dp_edge = dp_s2 ^ dp_prev;

  // Bit-period counter; every D+ transition re-centres the sample point.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)             cnt <= '0;
    else if (dp_edge)       cnt <= CW'(1);
    else if (cnt == LAST)   cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  // Never sample on the edge cycle itself, so the J->K that starts SYNC is
  // always decoded against the preceding J level.
  assign samp       = (cnt == HALF) && !dp_edge;
  assign se0        = !dp_s2 && !dm_s2;
  assign line_j     = dp_s2 && !dm_s2;
  assign bit_d      = (dp_s2 == last_lvl);
  assign stuff      = (ones == 3'd6);
  assign bit_v      = samp && !se0 && !stuff;
  assign byte_done  = bit_v && (bit_cnt == 3'd7);
  assign byte_w     = {bit_d, sr[7:1]};
  assign kind       = pid_kind(byte_w);
  assign sync_start = (state == S_IDLE) && dp_edge && !dp_s2 && dm_s2;
  assign occ_full   = (bus.buffer_occupancy >= 7'd64);

  // NRZI decode, unstuffing and LSB-first byte assembly.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_lvl <= 1'b1;
      ones     <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
    end else if (sync_start) begin
      last_lvl <= 1'b1;
      ones     <= '0;
      bit_cnt  <= '0;
    end else if (samp) begin
      last_lvl <= dp_s2;
      if (se0) begin
        ones    <= '0;
        bit_cnt <= '0;
      end else if (stuff) begin
        ones <= '0;
      end else begin
        ones    <= bit_d ? ones + 3'd1 : 3'd0;
        sr      <= byte_w;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= nxt;
  end

  // FSM: next state
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (sync_start) nxt = S_SYNC;
      S_EOP:  if (line_j) nxt = S_IDLE;
      default: begin
        if (samp && se0) begin
          nxt = S_EOP;
        end else begin
          case (state)
            S_SYNC: if (byte_done) nxt = (byte_w == 8'h80) ? S_PID : S_ERR_WAIT;
            S_PID: begin
              if (byte_done) begin
                case (kind)
                  K_TOKEN: nxt = S_TOKEN;
                  K_DATA:  nxt = S_DATA;
                  K_HS:    nxt = S_HANDSHAKE;
                  default: nxt = S_ERR_WAIT;
                endcase
              end
            end
            S_DATA:      if (byte_done && occ_full) nxt = S_ERR_WAIT;
            S_HANDSHAKE: if (bit_v) nxt = S_ERR_WAIT;
            default:     nxt = state;
          endcase
        end
      end
    endcase
  end

  // FSM: output decode
  always_comb begin
    pkt_load  = 1'b0;
    data_load = 1'b0;
    store_d   = 1'b0;
    flush_d   = 1'b0;
    err_set   = 1'b0;
    ready_d   = 1'b0;
    eop_done  = 1'b0;
    case (state)
      S_SYNC: err_set = byte_done && (byte_w != 8'h80);
      S_PID: begin
        pkt_load = byte_done;
        flush_d  = byte_done && (kind == K_DATA);
        err_set  = byte_done && (kind == K_BAD);
      end
      S_TOKEN: data_load = byte_done && (tok_cnt != 2'd2);
      S_DATA: begin
        store_d   = byte_done && !occ_full;
        data_load = byte_done && !occ_full;
        err_set   = byte_done && occ_full;
      end
      S_HANDSHAKE: err_set = bit_v;
      S_EOP: begin
        eop_done = line_j;
        ready_d  = line_j && data_pkt && !rx_error_q;
      end
      default: ;
    endcase
    // EOP arriving mid-byte is a truncated packet.
    if ((state != S_IDLE) && (state != S_EOP) && samp && se0 && (bit_cnt != 3'd0))
      err_set = 1'b1;
  end

  // Output and packet-tracking registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_packet_q      <= 4'b0000;
      rx_packet_data_q <= 8'hFF;
      store_q          <= 1'b0;
      flush_q          <= 1'b0;
      rx_error_q       <= 1'b0;
      trans_active_q   <= 1'b0;
      ready_q          <= 1'b0;
      tok_cnt          <= '0;
      data_pkt         <= 1'b0;
    end else begin
      store_q <= store_d;
      flush_q <= flush_d;
      ready_q <= ready_d;
      if (sync_start) begin
        rx_error_q     <= 1'b0;
        trans_active_q <= 1'b1;
        data_pkt       <= 1'b0;
      end else begin
        if (err_set)  rx_error_q     <= 1'b1;
        if (eop_done) trans_active_q <= 1'b0;
        if (flush_d)  data_pkt       <= 1'b1;
      end
      if (pkt_load) begin
        rx_packet_q <= byte_w[3:0];
        tok_cnt     <= '0;
      end else if ((state == S_TOKEN) && byte_done && (tok_cnt != 2'd2)) begin
        tok_cnt <= tok_cnt + 2'd1;
      end
      if (data_load) rx_packet_data_q <= byte_w;
    end
  end

  assign bus.rx_packet            = rx_packet_q;
  assign bus.rx_packet_data       = rx_packet_data_q;
  assign bus.store_rx_packet_data = store_q;
  assign bus.flush                = flush_q;
  assign bus.rx_error             = rx_error_q;
  assign bus.rx_trans_active      = trans_active_q;
  assign bus.rx_data_ready        = ready_q;
endmodule

// File: tb/tb_usb_rx.sv
// tb/tb_usb_rx.sv - scoreboard testbench for usb_rx with a packet-level reference model
module tb_usb_rx;
  localparam int BP = 5;
  localparam int EV_FLUSH = 0;
  localparam int EV_STORE = 1;
  localparam int EV_READY = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  logic tb_clk;
  logic n_rst;
  int   checks;
  int   failures;
  ev_t  exp_q[$];
  logic [3:0] m_pkt;
  logic [7:0] m_data;
  logic       m_err;
  logic [7:0] valid_pids [7];

  usb_rx_if bus();

  usb_rx #(.BIT_PERIOD(BP)) dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic ev_check(input int kind, input logic [7:0] val, input string name);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got unexpected strobe val=%h expected none", name, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_STORE && e.val !== val)) begin
        failures++;
        $display("FAIL %s: got kind=%0d val=%h expected kind=%0d val=%h", name, kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard.
  always @(negedge tb_clk) begin
    if (n_rst === 1'b1) begin
      if (bus.flush === 1'b1) ev_check(EV_FLUSH, 8'h00, "flush");
      if (bus.store_rx_packet_data === 1'b1) ev_check(EV_STORE, bus.rx_packet_data, "store");
      if (bus.rx_data_ready === 1'b1) ev_check(EV_READY, 8'h00, "data_ready");
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  task automatic drive_lvl(input logic dp, input logic dm);
    bus.dplus_in  = dp;
    bus.dminus_in = dm;
    tick(BP);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_packet", bus.rx_packet, 4'b0000);
    check("rst_rx_packet_data", bus.rx_packet_data, 8'hFF);
    check("rst_store", bus.store_rx_packet_data, 1'b0);
    check("rst_flush", bus.flush, 1'b0);
    check("rst_rx_error", bus.rx_error, 1'b0);
    check("rst_trans_active", bus.rx_trans_active, 1'b0);
    check("rst_data_ready", bus.rx_data_ready, 1'b0);
  endtask

  function automatic int pid_class(input logic [7:0] p);
    case (p)
      8'hE1, 8'h69:        return 1;
      8'hC3, 8'h4B:        return 2;
      8'hD2, 8'h5A, 8'h1E: return 3;
      default:             return 0;
    endcase
  endfunction

  // Packet-level reference: b[0] is the SYNC byte, b[1] the PID, rest payload;
  // extra = stray bits (<8) before EOP.
  task automatic model_packet(input bq_t b, input int extra, input int occ);
    m_err = 1'b0;
    if (b[0] != 8'h80) begin
      m_err = 1'b1;
      return;
    end
    m_pkt = b[1][3:0];
    case (pid_class(b[1]))
      1: begin
        for (int i = 2; i < b.size() && i < 4; i++) m_data = b[i];
        if (extra != 0) m_err = 1'b1;
      end
      2: begin
        exp_q.push_back('{EV_FLUSH, 8'h00});
        for (int i = 2; i < b.size(); i++) begin
          if (occ >= 64) begin
            m_err = 1'b1;
            break;
          end
          exp_q.push_back('{EV_STORE, b[i]});
          m_data = b[i];
        end
        if (extra != 0) m_err = 1'b1;
        if (!m_err) exp_q.push_back('{EV_READY, 8'h00});
      end
      3: if (b.size() > 2 || extra != 0) m_err = 1'b1;
      default: m_err = 1'b1;
    endcase
  endtask

  // Serialise LSB first, stuff a 0 after six 1s, NRZI encode, then SE0 SE0 J.
  // abort_at >= 0 pulls reset at that line-bit index instead of finishing.
  task automatic drive_packet(input bq_t b, input int extra, input int abort_at);
    logic bits[$];
    logic lv[$];
    logic lvl;
    int   ones;
    for (int i = 0; i < b.size(); i++)
      for (int j = 0; j < 8; j++) bits.push_back(b[i][j]);
    for (int i = 0; i < extra; i++) bits.push_back(1'($urandom_range(0, 1)));
    lvl  = 1'b1;
    ones = 0;
    for (int i = 0; i < bits.size(); i++) begin
      if (!bits[i]) lvl = ~lvl;
      lv.push_back(lvl);
      if (bits[i]) begin
        ones++;
        if (ones == 6) begin
          lvl = ~lvl;
          lv.push_back(lvl);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
    for (int i = 0; i < lv.size(); i++) begin
      if (i == 10) check("trans_active_mid", bus.rx_trans_active, 1'b1);
      if (i == abort_at) begin
        n_rst = 1'b0;
        #2;
        check_reset_outputs();
        bus.dplus_in  = 1'b1;
        bus.dminus_in = 1'b0;
        tick(3);
        n_rst = 1'b1;
        m_pkt  = 4'b0000;
        m_data = 8'hFF;
        m_err  = 1'b0;
        repeat (4) drive_lvl(1'b1, 1'b0);
        return;
      end
      drive_lvl(lv[i], ~lv[i]);
    end
    drive_lvl(1'b0, 1'b0);
    drive_lvl(1'b0, 1'b0);
    drive_lvl(1'b1, 1'b0);
  endtask

  task automatic run_pkt(input bq_t b, input int extra, input int occ);
    bus.buffer_occupancy = 7'(occ);
    model_packet(b, extra, occ);
    drive_packet(b, extra, -1);
    repeat (4) drive_lvl(1'b1, 1'b0);
    check("rx_packet", bus.rx_packet, m_pkt);
    check("rx_packet_data", bus.rx_packet_data, m_data);
    check("rx_error", bus.rx_error, m_err);
    check("trans_active_end", bus.rx_trans_active, 1'b0);
    check("events_drained", exp_q.size(), 0);
  endtask

  initial begin
    bq_t        p;
    logic [7:0] pid;
    logic [7:0] b0;
    int         nb;
    int         extra;
    int         occ;

    checks   = 0;
    failures = 0;
    m_pkt    = 4'b0000;
    m_data   = 8'hFF;
    m_err    = 1'b0;
    valid_pids = '{8'hE1, 8'h69, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E};

    n_rst = 1'b0;
    bus.dplus_in = 1'b1;
    bus.dminus_in = 1'b0;
    bus.buffer_occupancy = 7'd0;
    tick(3);
    check_reset_outputs();
    n_rst = 1'b1;
    repeat (3) drive_lvl(1'b1, 1'b0);

    // Directed cases
    p = {8'hAA, 8'h12, 8'h34};                 run_pkt(p, 0, 0);
    p = {8'h80, 8'hD2};                        run_pkt(p, 0, 0);
    p = {8'h80, 8'hC3, 8'hAA, 8'hFF, 8'hFF};   run_pkt(p, 0, 0);
    p = {8'h80, 8'h69, 8'hAA, 8'hAA};          run_pkt(p, 0, 0);
    p = {8'h80, 8'hFF};                        run_pkt(p, 0, 0);
    repeat (10) drive_lvl(1'b1, 1'b0);
    check("rx_error_sticky", bus.rx_error, 1'b1);
    p = {8'h80, 8'h4B, 8'h11, 8'h22};          run_pkt(p, 0, 64);
    p = {8'h80, 8'h4B, 8'h33, 8'hFF};          run_pkt(p, 0, 63);
    p = {8'h80, 8'hE1, 8'h01, 8'h02, 8'h03};   run_pkt(p, 0, 0);
    p = {8'h80, 8'hC3, 8'h5C};                 run_pkt(p, 3, 0);
    p = {8'h80, 8'h5A, 8'h00};                 run_pkt(p, 0, 0);
    p = {8'h80, 8'hC3, 8'h55, 8'h66};
    drive_packet(p, 0, 12);
    p = {8'h80, 8'h1E};                        run_pkt(p, 0, 0);

    // Randomized packets
    for (int n = 0; n < 40; n++) begin
      p.delete();
      if ($urandom_range(0, 9) == 0) begin
        b0 = 8'($urandom) & 8'hFE;
        if (b0 == 8'h80) b0 = 8'h02;
      end else begin
        b0 = 8'h80;
      end
      if ($urandom_range(0, 9) == 0) pid = 8'($urandom);
      else pid = valid_pids[$urandom_range(0, 6)];
      p.push_back(b0);
      p.push_back(pid);
      nb = $urandom_range(0, 5);
      if (pid_class(pid) == 3 && $urandom_range(0, 3) != 0) nb = 0;
      for (int i = 0; i < nb; i++)
        p.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      extra = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      occ   = ($urandom_range(0, 4) == 0) ? 64 : $urandom_range(0, 63);
      run_pkt(p, extra, occ);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_rx.md
# usb_rx

USB full-speed receive front end: recovers bits from the D+/D- pair (NRZI decode, bit-unstuffing, EOP detection), validates SYNC and PID, reports the packet type, and streams DATA-packet bytes into the downstream RX FIFO. It sits between the USB pins and the RX data buffer/AHB slave logic.

## Interface
- BIT_PERIOD, 5: clocks per USB bit; sample point is BIT_PERIOD/2 clocks after the last resync edge.
- clk  in  1  system clock
- n_rst  in  1  reset; one clock, asynchronous, active-low
- dplus_in  in  1  D+ line (idle J: dplus=1, dminus=0)
- dminus_in  in  1  D- line
- buffer_occupancy  in  7  current FIFO byte count, 0..64
- rx_packet  out  4  last received PID nibble; reset 4'b0000
- rx_packet_data  out  8  last completed byte after the PID; reset 8'hFF
- store_rx_packet_data  out  1  one-cycle strobe: push rx_packet_data into FIFO; reset 0
- flush  out  1  one-cycle strobe on DATA0/DATA1 PID acceptance; reset 0
- rx_error  out  1  packet error flag, sticky until next SYNC start; reset 0
- rx_trans_active  out  1  high from SYNC start to EOP completion; reset 0
- rx_data_ready  out  1  one-cycle strobe: DATA packet ended cleanly; reset 0

## Operation
- Inputs pass through 2-flop synchronizers. A transition of synchronized D+ restarts the bit counter (resync); bit sampled at count BIT_PERIOD/2, then every BIT_PERIOD clocks.
- NRZI: transition from previous sampled level = 0, no transition = 1. Bytes assembled LSB first.
- Unstuffing: after six consecutive decoded 1s the next bit is discarded unconditionally (no error).
- SE0: both lines sampled low.
- FSM states: IDLE, SYNC, PID, TOKEN, DATA, HANDSHAKE, ERR_WAIT, EOP.
  - IDLE: first J->K transition -> SYNC; clear rx_error; raise rx_trans_active.
  - SYNC: 8 bits must equal 8'h80 (seven 0s, then 1). Else rx_error=1 -> ERR_WAIT.
  - PID: 8 bits; rx_packet <= low nibble. Valid iff high nibble == ~low nibble and low nibble in {0001 OUT, 1001 IN, 0011 DATA0, 1011 DATA1, 0010 ACK, 1010 NAK, 1110 STALL}. Invalid -> rx_error=1, ERR_WAIT. OUT/IN -> TOKEN; DATA0/1 -> pulse flush, DATA; ACK/NAK/STALL -> HANDSHAKE.
  - TOKEN: capture up to 2 bytes into rx_packet_data, never stored.
  - DATA: each completed byte -> rx_packet_data updated and store_rx_packet_data pulsed same cycle, including CRC16 bytes (no CRC check; consumer strips). If buffer_occupancy >= 64 at store time: no strobe, rx_error=1.
  - HANDSHAKE: any data bit before EOP -> rx_error=1.
  - Any state: SE0 at a sample point -> EOP. If not on a byte boundary (bit count != 0) outside IDLE -> rx_error=1.
  - ERR_WAIT: ignore bits until SE0 -> EOP.
  - EOP: wait for J; then drop rx_trans_active, pulse rx_data_ready if packet was DATA with no error, -> IDLE.
- rx_packet and rx_packet_data hold values between packets.

## Timing
- rx_packet valid within 4 clocks of the PID's last bit sample point (2 sync + 1 sample + 1 register).
- store_rx_packet_data / rx_packet_data same latency after the byte's last bit; strobes exactly one clock.
- flush asserts one clock, at PID acceptance, before any store strobe of that packet.
- rx_error asserts within 4 clocks of detecting the fault; holds until next SYNC start or reset.
- n_rst low mid-packet: immediate return to IDLE with all outputs at reset values.

## Test plan
- Reset -> rx_packet=0000, rx_packet_data=FF, all strobes/flags 0.
- SYNC, PID ACK (byte 8'hD2), EOP -> rx_packet=0010, rx_error=0, no flush/store, rx_packet_data=FF, rx_trans_active falls after EOP.
- SYNC, DATA0 (8'hC3), bytes 8'hAA, 8'hFF, 8'hFF, EOP -> one flush, three store strobes (AA, FF, FF; stuffed bit after six 1s removed), rx_data_ready pulse, rx_error=0.
- SYNC, IN (8'h69), two bytes 8'hAA, EOP -> rx_packet=1001, rx_packet_data=AA, no store strobes, rx_error=0.
- SYNC, PID byte 8'hFF -> rx_packet=1111, rx_error=1, no flush; remains 1 until next SYNC.
- First byte 8'hAA instead of SYNC -> rx_error=1, rx_packet_data=FF; DATA1 packet with buffer_occupancy=64 -> no store, rx_error=1.
